// File: rtl/lcms_meas_sequencer.sv
// LCMS2012 measurement-channel timing scheduler.
// Builds the integrator/post-amp reset waveforms, the CDS clocks and the ADC
// conversion requests from microsecond-unit configuration words. Everything
// runs on s_clk. Waveforms are updated in the cycle after each us_cnt change.
module lcms_meas_sequencer #(
   parameter int CLK_PER_US = 100,
   parameter int TW         = 16
) (
   input  logic          s_clk,
   input  logic          reset,
   input  logic          start_meas,
   input  logic [TW-1:0] reset_period_i,
   input  logic [TW-1:0] int_reset_duration_i,
   input  logic [TW-1:0] post_reset_duration_i,
   input  logic [TW-1:0] v_sampling_period_i,
   input  logic [TW-1:0] cds_time1_delay_i,
   input  logic [TW-1:0] cds_time2_delay_i,
   input  logic [TW-1:0] cds_width_i,
   input  logic          mode_i,
   input  logic          mode2_i,
   input  logic          adc_busy_i,
   output logic          int_reset_o,
   output logic          post_reset_o,
   output logic          cds_clk1_o,
   output logic          cds_clk2_o,
   output logic          adc_cnv_start_o,
   output logic [1:0]    adc_tag_o,
   output logic          frame_start_o,
   output logic          overrun_o,
   output logic          cfg_err_o,
   output logic          busy_o
);
   localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_STOP} state_t;

   state_t          state_q;
   logic            start_q, upd_q;
   logic [PW-1:0]   pre_q;
   logic [TW-1:0]   us_q, samp_q;
   logic [TW-1:0]   per_q, intd_q, postd_q, sper_q, t1_q, t2_q, w_q;
   logic [1:0]      mode_q;
   logic            int_q, post_q, cds1_q, cds2_q, cnv_q, fs_q, ovr_q, cerr_q, busy_q;
   logic [1:0]      tag_q;

   logic            us_tick, us_last, samp_last, start_rise, cfg_bad, req;
   logic [1:0]      req_tag;
   logic [TW:0]     us_x, t1_x, t2_x, t1_end, t2_end;

   // Tick/wrap decode, CDS window bounds and request selection for the current us
   always_comb begin
      us_tick    = (pre_q == PW'(CLK_PER_US - 1));
      us_last    = (us_q == per_q - TW'(1));
      samp_last  = (samp_q == sper_q - TW'(1));
      start_rise = start_meas & ~start_q;
      cfg_bad    = (reset_period_i == '0) ||
                   ((mode_i == mode2_i) && (v_sampling_period_i == '0));
      us_x       = {1'b0, us_q};
      t1_x       = {1'b0, t1_q};
      t2_x       = {1'b0, t2_q};
      t1_end     = t1_x + {1'b0, w_q};
      t2_end     = t2_x + {1'b0, w_q};
      req        = 1'b0;
      req_tag    = 2'd0;
      case (mode_q)
         2'b10: begin
            // t1 takes precedence when both offsets coincide
            if (us_q == t1_q) begin
               req = 1'b1; req_tag = 2'd1;
            end else if (us_q == t2_q) begin
               req = 1'b1; req_tag = 2'd2;
            end
         end
         2'b01: begin
            // us_x never reaches period, so t2+width past the frame never fires
            if (us_x == t2_end) begin
               req = 1'b1; req_tag = 2'd3;
            end
         end
         default: begin
            if (samp_q == '0) begin
               req = 1'b1; req_tag = 2'd0;
            end
         end
      endcase
   end

   // Sequencer FSM with counters and registered waveform/request outputs
   always_ff @(posedge s_clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         // Seed with the live level so a start held through reset is not a rising edge
         start_q <= start_meas;
         upd_q   <= 1'b0;
         pre_q   <= '0;
         us_q    <= '0;
         samp_q  <= '0;
         per_q   <= '0; intd_q <= '0; postd_q <= '0; sper_q <= '0;
         t1_q    <= '0; t2_q   <= '0; w_q     <= '0; mode_q <= '0;
         int_q   <= 1'b0; post_q <= 1'b0; cds1_q <= 1'b0; cds2_q <= 1'b0;
         cnv_q   <= 1'b0; tag_q  <= '0;   fs_q   <= 1'b0;
         ovr_q   <= 1'b0; cerr_q <= 1'b0; busy_q <= 1'b0;
      end else begin
         start_q <= start_meas;
         upd_q   <= 1'b0;
         fs_q    <= 1'b0;
         cnv_q   <= 1'b0;
         tag_q   <= '0;
         case (state_q)
            S_IDLE: begin
               pre_q <= '0;
               if (start_rise) begin
                  per_q   <= reset_period_i;
                  intd_q  <= int_reset_duration_i;
                  postd_q <= post_reset_duration_i;
                  sper_q  <= v_sampling_period_i;
                  t1_q    <= cds_time1_delay_i;
                  t2_q    <= cds_time2_delay_i;
                  w_q     <= cds_width_i;
                  mode_q  <= {mode_i, mode2_i};
                  ovr_q   <= 1'b0;
                  cerr_q  <= cfg_bad;
                  if (!cfg_bad) begin
                     state_q <= S_ARM;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_ARM: begin
               pre_q   <= '0;
               us_q    <= '0;
               samp_q  <= '0;
               upd_q   <= 1'b1;
               state_q <= S_RUN;
            end
            S_RUN, S_STOP: begin
               if (upd_q) begin
                  int_q  <= (us_q < intd_q);
                  post_q <= (us_q < postd_q);
                  cds1_q <= (mode_q == 2'b01) && (us_x >= t1_x) && (us_x < t1_end);
                  cds2_q <= (mode_q == 2'b01) && (us_x >= t2_x) && (us_x < t2_end);
                  fs_q   <= (us_q == '0);
                  if (req) begin
                     if (adc_busy_i) begin
                        ovr_q <= 1'b1;
                     end else begin
                        cnv_q <= 1'b1;
                        tag_q <= req_tag;
                     end
                  end
               end
               if (us_tick) begin
                  pre_q <= '0;
                  if (us_last && (state_q == S_STOP)) begin
                     // Frame finished after stop: park with everything low
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     int_q   <= 1'b0; post_q <= 1'b0;
                     cds1_q  <= 1'b0; cds2_q <= 1'b0;
                     fs_q    <= 1'b0; cnv_q  <= 1'b0; tag_q <= '0;
                  end else begin
                     us_q   <= us_last ? '0 : us_q + TW'(1);
                     samp_q <= (us_last || samp_last) ? '0 : samp_q + TW'(1);
                     upd_q  <= 1'b1;
                  end
               end else begin
                  pre_q <= pre_q + PW'(1);
               end
               if ((state_q == S_RUN) && !start_meas) state_q <= S_STOP;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign int_reset_o     = int_q;
   assign post_reset_o    = post_q;
   assign cds_clk1_o      = cds1_q;
   assign cds_clk2_o      = cds2_q;
   assign adc_cnv_start_o = cnv_q;
   assign adc_tag_o       = tag_q;
   assign frame_start_o   = fs_q;
   assign overrun_o       = ovr_q;
   assign cfg_err_o       = cerr_q;
   assign busy_o          = busy_q;
endmodule

// File: tb/tb_lcms_meas_sequencer.sv
// Directed bench for lcms_meas_sequencer with a 4-cycle microsecond.
// Outputs are traced per cycle on the falling edge; checks measure positions
// and counts relative to frame_start_o.
module tb_lcms_meas_sequencer;
   localparam int CPU = 4;
   localparam int TRN = 8192;

   logic        s_clk, reset, start_meas, mode_i, mode2_i, adc_busy_i;
   logic [15:0] reset_period_i, int_reset_duration_i, post_reset_duration_i;
   logic [15:0] v_sampling_period_i, cds_time1_delay_i, cds_time2_delay_i, cds_width_i;
   logic        int_reset_o, post_reset_o, cds_clk1_o, cds_clk2_o, adc_cnv_start_o;
   logic [1:0]  adc_tag_o;
   logic        frame_start_o, overrun_o, cfg_err_o, busy_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [7:0] tr [0:TRN-1];

   lcms_meas_sequencer #(.CLK_PER_US(CPU), .TW(16)) dut (
      .s_clk(s_clk), .reset(reset), .start_meas(start_meas),
      .reset_period_i(reset_period_i), .int_reset_duration_i(int_reset_duration_i),
      .post_reset_duration_i(post_reset_duration_i), .v_sampling_period_i(v_sampling_period_i),
      .cds_time1_delay_i(cds_time1_delay_i), .cds_time2_delay_i(cds_time2_delay_i),
      .cds_width_i(cds_width_i), .mode_i(mode_i), .mode2_i(mode2_i), .adc_busy_i(adc_busy_i),
      .int_reset_o(int_reset_o), .post_reset_o(post_reset_o), .cds_clk1_o(cds_clk1_o),
      .cds_clk2_o(cds_clk2_o), .adc_cnv_start_o(adc_cnv_start_o), .adc_tag_o(adc_tag_o),
      .frame_start_o(frame_start_o), .overrun_o(overrun_o), .cfg_err_o(cfg_err_o),
      .busy_o(busy_o)
   );

   initial s_clk = 1'b0;
   always #5 s_clk = ~s_clk;

   always @(posedge s_clk) cyc <= cyc + 1;

   // trace bits: 0 int, 1 post, 2 clk1, 3 clk2, 4 cnv, 5 fs, 7:6 tag
   always @(negedge s_clk)
      if (cyc < TRN)
         tr[cyc] = {adc_tag_o, frame_start_o, adc_cnv_start_o,
                    cds_clk2_o, cds_clk1_o, post_reset_o, int_reset_o};

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int cnt(input int b, input int from, input int to);
      int n = 0;
      for (int i = from; i < to; i++)
         if (i >= 0 && i < TRN && tr[i][b] === 1'b1) n++;
      return n;
   endfunction

   function automatic int nxt(input int b, input int from);
      for (int i = (from < 0 ? 0 : from); i < TRN && i < cyc; i++)
         if (tr[i][b] === 1'b1) return i;
      return -1;
   endfunction

   function automatic int tag_at(input int i);
      if (i < 0 || i >= TRN) return -1;
      return int'(tr[i][7:6]);
   endfunction

   task automatic setcfg(input int per, input int intd, input int postd, input int samp,
                         input int t1, input int t2, input int w,
                         input logic m1, input logic m2);
      reset_period_i        = per[15:0];
      int_reset_duration_i  = intd[15:0];
      post_reset_duration_i = postd[15:0];
      v_sampling_period_i   = samp[15:0];
      cds_time1_delay_i     = t1[15:0];
      cds_time2_delay_i     = t2[15:0];
      cds_width_i           = w[15:0];
      mode_i                = m1;
      mode2_i               = m2;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge s_clk);
   endtask

   task automatic wait_fs(output int f);
      f = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge s_clk);
         if (frame_start_o === 1'b1) begin
            f = cyc;
            break;
         end
      end
      if (f < 0) begin
         chk("fs_timeout", 0, 1);
         f = cyc;
      end
   endtask

   task automatic stop_wait_idle();
      int ok;
      @(negedge s_clk);
      start_meas = 1'b0;
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge s_clk);
         if (busy_o === 1'b0) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) chk("idle_timeout", 0, 1);
      idle(2);
   endtask

   initial begin
      int st, f, fs1, fs2, fs3;
      reset = 1'b0; start_meas = 1'b0; adc_busy_i = 1'b0;
      setcfg(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      idle(3);
      chk("rst_outs", int'({int_reset_o, post_reset_o, cds_clk1_o, cds_clk2_o, adc_cnv_start_o,
                            adc_tag_o, frame_start_o, overrun_o, cfg_err_o, busy_o}), 0);
      reset = 1'b1;
      idle(2);

      // Mode 00 plain sampling; samp=6 so the frame wrap must restart samp_cnt
      setcfg(20, 3, 5, 6, 0, 0, 0, 1'b0, 1'b0);
      @(negedge s_clk); st = cyc; start_meas = 1'b1;
      idle(250);
      fs1 = nxt(5, st); fs2 = nxt(5, fs1 + 1); fs3 = nxt(5, fs2 + 1);
      chk("a_fs_latency", fs1 - st, 3);
      chk("a_frame1", fs2 - fs1, 20 * CPU);
      chk("a_frame2", fs3 - fs2, 20 * CPU);
      chk("a_int_cycles", cnt(0, fs1, fs2), 3 * CPU);
      chk("a_post_cycles", cnt(1, fs1, fs2), 5 * CPU);
      chk("a_int_fall", cnt(0, fs1, fs1 + 3 * CPU + 1), 3 * CPU);
      chk("a_req_cnt", cnt(4, fs1, fs2), 4);
      chk("a_req_at_fs", nxt(4, fs1) - fs1, 0);
      chk("a_req_gap", nxt(4, fs1 + 1) - fs1, 6 * CPU);
      chk("a_req_fs2", nxt(4, fs2) - fs2, 0);
      chk("a_tag", tag_at(fs1), 0);
      chk("a_no_cds", cnt(2, fs1, fs3) + cnt(3, fs1, fs3), 0);
      chk("a_busy", int'(busy_o), 1);
      stop_wait_idle();

      // Mode 11 behaves as plain
      setcfg(20, 3, 5, 5, 0, 0, 0, 1'b1, 1'b1);
      @(negedge s_clk); start_meas = 1'b1;
      wait_fs(f); idle(100);
      chk("m11_req_cnt", cnt(4, f, f + 20 * CPU), 4);
      stop_wait_idle();

      // Mode 01 hardware CDS
      setcfg(20, 0, 0, 0, 2, 14, 2, 1'b0, 1'b1);
      @(negedge s_clk); start_meas = 1'b1;
      wait_fs(f); idle(100);
      chk("b_clk1_rise", nxt(2, f) - f, 2 * CPU);
      chk("b_clk1_cycles", cnt(2, f, f + 20 * CPU), 2 * CPU);
      chk("b_clk2_rise", nxt(3, f) - f, 14 * CPU);
      chk("b_clk2_cycles", cnt(3, f, f + 20 * CPU), 2 * CPU);
      chk("b_req_pos", nxt(4, f) - f, 16 * CPU);
      chk("b_req_cnt", cnt(4, f, f + 20 * CPU), 1);
      chk("b_tag", tag_at(nxt(4, f)), 3);
      stop_wait_idle();
      // t2+width reaches the period: clock truncated, no request
      setcfg(20, 0, 0, 0, 2, 18, 2, 1'b0, 1'b1);
      @(negedge s_clk); start_meas = 1'b1;
      wait_fs(f); idle(100);
      chk("b2_req_cnt", cnt(4, f, f + 20 * CPU), 0);
      chk("b2_clk2_cycles", cnt(3, f, f + 20 * CPU), 2 * CPU);
      stop_wait_idle();

      // Mode 10 software CDS with ADC busy across the t2 request
      setcfg(20, 0, 0, 0, 2, 14, 0, 1'b1, 1'b0);
      @(negedge s_clk); start_meas = 1'b1;
      wait_fs(f);
      idle(47); adc_busy_i = 1'b1;
      idle(17); adc_busy_i = 1'b0;
      idle(100);
      chk("c_req1_pos", nxt(4, f) - f, 2 * CPU);
      chk("c_tag1", tag_at(f + 2 * CPU), 1);
      chk("c_req_cnt", cnt(4, f, f + 20 * CPU), 1);
      chk("c_overrun", int'(overrun_o), 1);
      chk("c_req_cnt2", cnt(4, f + 20 * CPU, f + 40 * CPU), 2);
      chk("c_tag2", tag_at(f + 34 * CPU), 2);
      stop_wait_idle();
      chk("c_overrun_idle", int'(overrun_o), 1);
      @(negedge s_clk); start_meas = 1'b1;
      idle(2);
      chk("c_overrun_clr", int'(overrun_o), 0);
      stop_wait_idle();

      // Stop mid-frame: current frame completes, then everything goes quiet
      setcfg(20, 3, 3, 5, 0, 0, 0, 1'b0, 1'b0);
      @(negedge s_clk); start_meas = 1'b1;
      wait_fs(f);
      idle(8 * CPU); start_meas = 1'b0;
      idle(120);
      chk("d_int_cont", cnt(0, f, f + 20 * CPU), 3 * CPU);
      chk("d_req_cont", cnt(4, f, f + 20 * CPU), 4);
      chk("d_no_fs", cnt(5, f + 1, f + 150), 0);
      chk("d_quiet", cnt(0, f + 20 * CPU - 1, f + 150) + cnt(1, f + 20 * CPU - 1, f + 150)
                     + cnt(4, f + 20 * CPU - 1, f + 150), 0);
      chk("d_busy", int'(busy_o), 0);

      // Invalid configurations
      setcfg(0, 3, 3, 5, 0, 0, 0, 1'b0, 1'b0);
      @(negedge s_clk); start_meas = 1'b1;
      idle(5);
      chk("e_cfg_err", int'(cfg_err_o), 1);
      chk("e_busy", int'(busy_o), 0);
      start_meas = 1'b0;
      setcfg(20, 3, 3, 0, 0, 0, 0, 1'b0, 1'b0);
      idle(2); start_meas = 1'b1; idle(5);
      chk("e_samp0_err", int'(cfg_err_o) + int'(busy_o), 1);
      start_meas = 1'b0;
      setcfg(20, 3, 3, 0, 2, 14, 0, 1'b1, 1'b0);
      idle(2); start_meas = 1'b1; idle(3);
      chk("e_cfg_clr", int'(cfg_err_o), 0);
      stop_wait_idle();

      // Reset mid-frame while int_reset_o is high
      setcfg(20, 10, 10, 5, 0, 0, 0, 1'b0, 1'b0);
      @(negedge s_clk); start_meas = 1'b1;
      wait_fs(f);
      idle(5 * CPU);
      chk("f_int_before", int'(int_reset_o), 1);
      reset = 1'b0;
      @(negedge s_clk);
      chk("f_rst_outs", int'({int_reset_o, post_reset_o, cds_clk1_o, cds_clk2_o, adc_cnv_start_o,
                              adc_tag_o, frame_start_o, overrun_o, cfg_err_o, busy_o}), 0);
      reset = 1'b1;
      st = cyc;
      idle(40);
      chk("f_stay_idle", int'(busy_o) + cnt(5, st, cyc), 0);
      start_meas = 1'b0; idle(1); start_meas = 1'b1;
      idle(10);
      chk("f_restart", int'(busy_o), 1);
      stop_wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
